// File: rtl/calc_pkg.sv
// Shared definitions for the calc result path: widths, byte indices and state encoding.
// Imported by the serializer, its checksum adder and the bench.
package calc_pkg;

   localparam int CALC_W = 8;

   localparam logic [2:0] IDX_W    = 3'd0;
   localparam logic [2:0] IDX_X    = 3'd1;
   localparam logic [2:0] IDX_Y    = 3'd2;
   localparam logic [2:0] IDX_Z    = 3'd3;
   localparam logic [2:0] IDX_CSUM = 3'd4;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_SEND = 1'b1
   } state_t;

   // Byte for a packet position; hold is packed {w, x, y, z}.
   function automatic logic [CALC_W-1:0] pick_byte(input logic [4*CALC_W-1:0] hold,
                                                   input logic [CALC_W-1:0]   csum,
                                                   input logic [2:0]          idx);
      logic [CALC_W-1:0] b;
      case (idx)
         IDX_W:   b = hold[4*CALC_W-1:3*CALC_W];
         IDX_X:   b = hold[3*CALC_W-1:2*CALC_W];
         IDX_Y:   b = hold[2*CALC_W-1:CALC_W];
         IDX_Z:   b = hold[CALC_W-1:0];
         default: b = csum;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/calc_csum8.sv
// Combinational 4-input modular adder; the packet checksum is the 8-bit sum of w, x, y, z.
module calc_csum8
   import calc_pkg::*;
(
   input  logic [CALC_W-1:0] a_i,
   input  logic [CALC_W-1:0] b_i,
   input  logic [CALC_W-1:0] c_i,
   input  logic [CALC_W-1:0] d_i,
   output logic [CALC_W-1:0] sum_o
);

   // Carries out of bit 7 are discarded by the 8-bit result width.
   assign sum_o = a_i + b_i + c_i + d_i;

endmodule

// File: rtl/calc_result_serializer.sv
// Serializes one {w,x,y,z} result set into a byte stream (optionally plus checksum),
// with back-to-back packet support and a wrapping packet counter.
module calc_result_serializer
   import calc_pkg::*;
#(
   parameter bit SEND_CSUM = 1'b1,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CALC_W-1:0] in_w,
   input  logic [CALC_W-1:0] in_x,
   input  logic [CALC_W-1:0] in_y,
   input  logic [CALC_W-1:0] in_z,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CALC_W-1:0] out_data,
   output logic [2:0]        out_idx,
   output logic              out_last,
   output logic [CNT_W-1:0]  pkt_count,
   output state_t            dbg_state
);

   // Handshakes: a transfer happens on a cycle where valid && ready are both high;
   // valid never depends on ready, and once raised stays up until its transfer.

   localparam logic [2:0] LAST = SEND_CSUM ? IDX_CSUM : IDX_Z;

   state_t              state_q, state_d;
   logic [4*CALC_W-1:0] hold_q, hold_d;
   logic [CALC_W-1:0]   csum_q, csum_d;
   logic [CALC_W-1:0]   out_data_q, out_data_d;
   logic [2:0]          out_idx_q, out_idx_d;
   logic                out_last_q, out_last_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic [CALC_W-1:0]   csum_in;
   logic                xfer;
   logic                cap;

   calc_csum8 u_csum (
      .a_i   (in_w),
      .b_i   (in_x),
      .c_i   (in_y),
      .d_i   (in_z),
      .sum_o (csum_in)
   );

   assign xfer      = (state_q == S_SEND) && out_ready;
   // Ready reopens during the final byte's transfer so the next set follows with no bubble.
   assign in_ready  = (state_q == S_IDLE) || (xfer && out_last_q);
   assign cap       = in_valid && in_ready;
   assign out_valid = (state_q == S_SEND);
   assign out_data  = out_data_q;
   assign out_idx   = out_idx_q;
   assign out_last  = out_last_q;
   assign pkt_count = cnt_q;
   assign dbg_state = state_q;

   always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      csum_d     = csum_q;
      out_data_d = out_data_q;
      out_idx_d  = out_idx_q;
      out_last_d = out_last_q;
      cnt_d      = cnt_q;

      if (xfer && !out_last_q) begin
         out_idx_d  = out_idx_q + 3'd1;
         out_data_d = pick_byte(hold_q, csum_q, out_idx_q + 3'd1);
         out_last_d = ((out_idx_q + 3'd1) == LAST);
      end

      if (xfer && out_last_q) begin
         cnt_d      = cnt_q + CNT_W'(1);
         state_d    = S_IDLE;
         out_data_d = '0;
         out_idx_d  = IDX_W;
         out_last_d = 1'b0;
      end

      // A capture overrides the return to idle when it coincides with the last transfer.
      if (cap) begin
         state_d    = S_SEND;
         hold_d     = {in_w, in_x, in_y, in_z};
         csum_d     = csum_in;
         out_data_d = in_w;
         out_idx_d  = IDX_W;
         out_last_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         hold_q     <= '0;
         csum_q     <= '0;
         out_data_q <= '0;
         out_idx_q  <= IDX_W;
         out_last_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         hold_q     <= hold_d;
         csum_q     <= csum_d;
         out_data_q <= out_data_d;
         out_idx_q  <= out_idx_d;
         out_last_q <= out_last_d;
         cnt_q      <= cnt_d;
      end
   end

endmodule

// File: tb/tb_calc_result_serializer.sv
// Directed bench: instance A (checksum on, 2-bit counter) and instance B (no checksum, 16-bit counter).
// A's counter runs 1,2,3,0 across the single, backpressure and back-to-back packets.
module tb_calc_result_serializer;
   import calc_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] in_w = '0, in_x = '0, in_y = '0, in_z = '0;

   logic       a_in_valid = 1'b0, a_out_ready = 1'b0;
   logic       a_in_ready, a_out_valid, a_out_last;
   logic [7:0] a_out_data;
   logic [2:0] a_out_idx;
   logic [1:0] a_pkt_count;
   state_t     a_state;

   logic       b_in_valid = 1'b0, b_out_ready = 1'b0;
   logic       b_in_ready, b_out_valid, b_out_last;
   logic [7:0] b_out_data;
   logic [2:0] b_out_idx;
   logic [15:0] b_pkt_count;
   state_t     b_state;

   int checks   = 0;
   int failures = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   calc_result_serializer #(.SEND_CSUM(1'b1), .CNT_W(2)) u_dut_a (
      .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_w(in_w), .in_x(in_x), .in_y(in_y), .in_z(in_z),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .out_idx(a_out_idx), .out_last(a_out_last), .pkt_count(a_pkt_count), .dbg_state(a_state)
   );

   calc_result_serializer #(.SEND_CSUM(1'b0), .CNT_W(16)) u_dut_b (
      .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_w(in_w), .in_x(in_x), .in_y(in_y), .in_z(in_z),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .out_idx(b_out_idx), .out_last(b_out_last), .pkt_count(b_pkt_count), .dbg_state(b_state)
   );

   task automatic set_inputs(input logic [7:0] w, x, y, z);
      in_w = w; in_x = x; in_y = y; in_z = z;
   endtask

   // Checks the remaining A stream against exp_q; byte index starts at first_idx.
   task automatic a_stream(input string name, input int first_idx, input int last_idx);
      int i;
      i = first_idx;
      while (exp_q.size() > 0) begin
         logic [7:0] e;
         e = exp_q.pop_front();
         checks++;
         if (a_out_valid !== 1'b1 || a_out_data !== e || a_out_idx !== 3'(i) ||
             a_out_last !== (i == last_idx)) begin
            failures++;
            $display("FAIL %s byte%0d: valid=%b data=%h idx=%0d last=%b, expected valid=1 data=%h idx=%0d last=%b",
                     name, i, a_out_valid, a_out_data, a_out_idx, a_out_last, e, i, (i == last_idx));
         end
         @(negedge clk);
         i++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_out_data !== 8'h00 || a_out_idx !== 3'd0 ||
          a_out_last !== 1'b0 || a_pkt_count !== 2'd0 || a_state !== S_IDLE) begin
         failures++;
         $display("FAIL reset_a: rdy=%b vld=%b data=%h idx=%0d last=%b cnt=%0d, expected 1 0 00 0 0 0",
                  a_in_ready, a_out_valid, a_out_data, a_out_idx, a_out_last, a_pkt_count);
      end
      checks++;
      if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0 || b_out_data !== 8'h00 || b_out_idx !== 3'd0 ||
          b_out_last !== 1'b0 || b_pkt_count !== 16'd0) begin
         failures++;
         $display("FAIL reset_b: rdy=%b vld=%b data=%h idx=%0d last=%b cnt=%0d, expected 1 0 00 0 0 0",
                  b_in_ready, b_out_valid, b_out_data, b_out_idx, b_out_last, b_pkt_count);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single();
      set_inputs(8'hFF, 8'h5C, 8'h1D, 8'h3F);
      a_in_valid = 1'b1; a_out_ready = 1'b1;
      checks++;
      if (a_in_ready !== 1'b1) begin
         failures++; $display("FAIL single_ready: in_ready=%b expected 1", a_in_ready);
      end
      @(negedge clk);
      a_in_valid = 1'b0;
      exp_q = '{8'hFF, 8'h5C, 8'h1D, 8'h3F, 8'hB7};
      a_stream("single", 0, 4);
      checks++;
      if (a_pkt_count !== 2'd1 || a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
         failures++;
         $display("FAIL single_end: cnt=%0d vld=%b rdy=%b, expected 1 0 1", a_pkt_count, a_out_valid, a_in_ready);
      end
   endtask

   task automatic test_no_csum();
      logic [7:0] e [4];
      e = '{8'hFF, 8'h5C, 8'h1D, 8'h3F};
      set_inputs(8'hFF, 8'h5C, 8'h1D, 8'h3F);
      b_in_valid = 1'b1; b_out_ready = 1'b1;
      @(negedge clk);
      b_in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (b_out_valid !== 1'b1 || b_out_data !== e[i] || b_out_idx !== 3'(i) || b_out_last !== (i == 3)) begin
            failures++;
            $display("FAIL nocsum byte%0d: valid=%b data=%h idx=%0d last=%b, expected 1 %h %0d %b",
                     i, b_out_valid, b_out_data, b_out_idx, b_out_last, e[i], i, (i == 3));
         end
         @(negedge clk);
      end
      checks++;
      if (b_out_valid !== 1'b0 || b_pkt_count !== 16'd1) begin
         failures++;
         $display("FAIL nocsum_end: vld=%b cnt=%0d, expected 0 1", b_out_valid, b_pkt_count);
      end
   endtask

   task automatic test_backpressure();
      set_inputs(8'hFF, 8'h5C, 8'h1D, 8'h3F);
      a_in_valid = 1'b1; a_out_ready = 1'b1;
      @(negedge clk);
      a_in_valid = 1'b0;
      exp_q = '{8'hFF};
      a_stream("bp_head", 0, 4);
      a_out_ready = 1'b0;
      // Field changes while not handshaking must not reach the packet.
      set_inputs(8'hAA, 8'hBB, 8'hCC, 8'hDD);
      for (int k = 0; k < 4; k++) begin
         if (k == 3) a_out_ready = 1'b1;
         checks++;
         if (a_out_valid !== 1'b1 || a_out_data !== 8'h5C || a_out_idx !== 3'd1 || a_out_last !== 1'b0 ||
             a_in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold%0d: vld=%b data=%h idx=%0d last=%b rdy=%b, expected 1 5c 1 0 0",
                     k, a_out_valid, a_out_data, a_out_idx, a_out_last, a_in_ready);
         end
         @(negedge clk);
      end
      exp_q = '{8'h1D, 8'h3F, 8'hB7};
      a_stream("bp_tail", 2, 4);
      checks++;
      if (a_pkt_count !== 2'd2 || a_out_valid !== 1'b0) begin
         failures++;
         $display("FAIL bp_end: cnt=%0d vld=%b, expected 2 0", a_pkt_count, a_out_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] e1 [5];
      e1 = '{8'hFF, 8'h5C, 8'h1D, 8'h3F, 8'hB7};
      set_inputs(8'hFF, 8'h5C, 8'h1D, 8'h3F);
      a_in_valid = 1'b1; a_out_ready = 1'b1;
      @(negedge clk);
      set_inputs(8'h01, 8'h02, 8'h03, 8'h04);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (a_out_valid !== 1'b1 || a_out_data !== e1[i] || a_out_idx !== 3'(i) || a_in_ready !== (i == 4)) begin
            failures++;
            $display("FAIL b2b_first%0d: vld=%b data=%h idx=%0d rdy=%b, expected 1 %h %0d %b",
                     i, a_out_valid, a_out_data, a_out_idx, a_in_ready, e1[i], i, (i == 4));
         end
         @(negedge clk);
      end
      a_in_valid = 1'b0;
      checks++;
      if (a_pkt_count !== 2'd3) begin
         failures++; $display("FAIL b2b_cnt1: cnt=%0d expected 3", a_pkt_count);
      end
      exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
      a_stream("b2b_second", 0, 4);
      checks++;
      if (a_pkt_count !== 2'd0 || a_out_valid !== 1'b0) begin
         failures++; $display("FAIL b2b_wrap: cnt=%0d vld=%b, expected 0 0", a_pkt_count, a_out_valid);
      end
   endtask

   task automatic test_reset_mid();
      set_inputs(8'hFF, 8'h5C, 8'h1D, 8'h3F);
      b_in_valid = 1'b1; b_out_ready = 1'b1;
      @(negedge clk);
      b_in_valid = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (b_out_data !== 8'h1D || b_pkt_count !== 16'd1) begin
         failures++; $display("FAIL rmid_pre: data=%h cnt=%0d, expected 1d 1", b_out_data, b_pkt_count);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1 || b_pkt_count !== 16'd0 || b_out_idx !== 3'd0) begin
         failures++;
         $display("FAIL rmid_async: vld=%b rdy=%b cnt=%0d idx=%0d, expected 0 1 0 0",
                  b_out_valid, b_in_ready, b_pkt_count, b_out_idx);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (b_out_valid !== 1'b0) begin
         failures++; $display("FAIL rmid_noresume: vld=%b expected 0", b_out_valid);
      end
      set_inputs(8'h01, 8'h02, 8'h03, 8'h04);
      b_in_valid = 1'b1;
      @(negedge clk);
      b_in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (b_out_valid !== 1'b1 || b_out_data !== 8'(i + 1) || b_out_idx !== 3'(i) || b_out_last !== (i == 3)) begin
            failures++;
            $display("FAIL rmid_next%0d: vld=%b data=%h idx=%0d last=%b, expected 1 %h %0d %b",
                     i, b_out_valid, b_out_data, b_out_idx, b_out_last, 8'(i + 1), i, (i == 3));
         end
         @(negedge clk);
      end
      checks++;
      if (b_pkt_count !== 16'd1) begin
         failures++; $display("FAIL rmid_cnt: cnt=%0d expected 1", b_pkt_count);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_no_csum();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
